krnl_acc_axi_ctrl_master: RTL and testbench

//  AXI4-Lite control-port master: the initiating end of the kernel control-register interface.

---
 rtl/krnl_acc_axi_ctrl_master_if.sv | 39 +++
 rtl/krnl_acc_axi_ctrl_master.sv | 153 +++++++++++++++
 tb/tb_krnl_acc_axi_ctrl_master.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/krnl_acc_axi_ctrl_master_if.sv
// rtl/krnl_acc_axi_ctrl_master_if.sv - AXI4-Lite channel bundle for the kernel control port
interface krnl_acc_axi_ctrl_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/krnl_acc_axi_ctrl_master.sv
// rtl/krnl_acc_axi_ctrl_master.sv - AXI4-Lite control master running write/read/poll register commands
module krnl_acc_axi_ctrl_master #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  input  logic [DATA_W-1:0]   cmd_mask,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  krnl_acc_axi_ctrl_master_if.master axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(POLL_MAX + 1);
  localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_MAX);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, WR_AW_W, WR_B, RD_AR, RD_R, POLL_GAP_WAIT, RESP
  } state_t;

  state_t state, nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] mask_q;
  logic              poll_q;
  logic              aw_done;
  logic              w_done;
  logic [CNT_W-1:0]  poll_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] rsp_data_q;
  logic [1:0]        rsp_resp_q;
  logic              rsp_timeout_q;

  logic aw_hs, w_hs, rd_match, rd_final, poll_exhausted;

  assign aw_hs = axi.AWVALID & axi.AWREADY;
  assign w_hs  = axi.WVALID & axi.WREADY;
  assign rd_match       = ((axi.RDATA ^ wdata_q) & mask_q) == '0;
  assign poll_exhausted = poll_cnt == CNT_MAX;
  // a plain read, a slave error, a match or the last allowed poll read all end the command
  assign rd_final = ~poll_q | (axi.RRESP != 2'b00) | rd_match | poll_exhausted;

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:          if (cmd_valid) nxt = (cmd_op == 2'b00) ? WR_AW_W : RD_AR;
      WR_AW_W:       if ((aw_done | aw_hs) & (w_done | w_hs)) nxt = WR_B;
      WR_B:          if (axi.BVALID) nxt = RESP;
      RD_AR:         if (axi.ARREADY) nxt = RD_R;
      RD_R:          if (axi.RVALID) nxt = rd_final ? RESP : POLL_GAP_WAIT;
      POLL_GAP_WAIT: if (gap_cnt == GAP_LAST) nxt = RD_AR;
      RESP:          if (rsp_ready) nxt = IDLE;
      default:       nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready   = (state == IDLE) & ~ARESET;
    axi.AWVALID = (state == WR_AW_W) & ~aw_done;
    axi.WVALID  = (state == WR_AW_W) & ~w_done;
    axi.BREADY  = (state == WR_B);
    axi.ARVALID = (state == RD_AR);
    axi.RREADY  = (state == RD_R);
    axi.AWADDR  = addr_q;
    axi.WDATA   = wdata_q;
    axi.WSTRB   = wstrb_q;
    axi.ARADDR  = addr_q;
    rsp_valid   = (state == RESP);
    rsp_data    = rsp_data_q;
    rsp_resp    = rsp_resp_q;
    rsp_timeout = rsp_timeout_q;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      mask_q        <= '0;
      poll_q        <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      poll_cnt      <= '0;
      gap_cnt       <= '0;
      rsp_data_q    <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            wdata_q  <= cmd_wdata;
            wstrb_q  <= cmd_wstrb;
            mask_q   <= cmd_mask;
            poll_q   <= (cmd_op == 2'b10);
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            poll_cnt <= CNT_W'(1);
          end
        end
        WR_AW_W: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        WR_B: begin
          if (axi.BVALID) begin
            rsp_resp_q    <= axi.BRESP;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
          end
        end
        RD_R: begin
          if (axi.RVALID) begin
            rsp_data_q    <= axi.RDATA;
            rsp_resp_q    <= axi.RRESP;
            rsp_timeout_q <= poll_q & (axi.RRESP == 2'b00) & ~rd_match & poll_exhausted;
            gap_cnt       <= '0;
          end
        end
        POLL_GAP_WAIT: begin
          gap_cnt <= gap_cnt + GAP_W'(1);
          // only reached below POLL_MAX, so the read count cannot wrap
          if (gap_cnt == GAP_LAST) poll_cnt <= poll_cnt + CNT_W'(1);
        end
        RESP: begin
          if (rsp_ready) rsp_timeout_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_krnl_acc_axi_ctrl_master.sv
// tb/tb_krnl_acc_axi_ctrl_master.sv - randomized bench with AXI-Lite slave model and command-level reference
module tb_krnl_acc_axi_ctrl_master;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int PG = 3;
  localparam int PM = 4;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic [DW-1:0] cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;

  krnl_acc_axi_ctrl_master_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  krnl_acc_axi_ctrl_master #(.ADDR_W(AW), .DATA_W(DW), .POLL_GAP(PG), .POLL_MAX(PM)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .axi(axi)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // slave plan and observations
  logic [DW-1:0] plan_d [PM];
  logic [1:0]    plan_r [PM];
  logic [1:0]    plan_b;
  bit            b_hold = 0, r_hold = 0;
  int            aw_cnt, w_cnt, ar_cnt, rd_idx;
  int            addr_bad, ar_unstable, gap_bad, gap_run;
  bit            aw_got, w_got, r_pend, b_hs, r_hs, gap_on, ar_wait;
  logic [AW-1:0] exp_addr, ar_hold, got_awaddr;
  logic [DW-1:0] got_wdata;
  logic [3:0]    got_wstrb;

  function automatic logic [4:0] dut_vr();
    return {axi.AWVALID, axi.WVALID, axi.ARVALID, axi.BREADY, axi.RREADY};
  endfunction

  initial begin
    axi.AWREADY = 0; axi.WREADY = 0; axi.ARREADY = 0;
    axi.BVALID = 0; axi.BRESP = 0; axi.RVALID = 0; axi.RDATA = 0; axi.RRESP = 0;
    forever begin
      @(posedge ACLK);
      b_hs = axi.BVALID && axi.BREADY;
      r_hs = axi.RVALID && axi.RREADY;
      if (ARESET) begin
        aw_got = 0; w_got = 0; r_pend = 0; gap_on = 0; ar_wait = 0; b_hs = 0; r_hs = 0;
        axi.BVALID = 0; axi.RVALID = 0;
      end else begin
        if (ar_wait && (!axi.ARVALID || axi.ARADDR !== ar_hold)) ar_unstable++;
        ar_wait = axi.ARVALID && !axi.ARREADY;
        ar_hold = axi.ARADDR;
        if (axi.AWVALID && axi.AWREADY) begin aw_cnt++; aw_got = 1; got_awaddr = axi.AWADDR; end
        if (axi.WVALID && axi.WREADY) begin w_cnt++; w_got = 1; got_wdata = axi.WDATA; got_wstrb = axi.WSTRB; end
        if (axi.ARVALID && axi.ARREADY) begin
          ar_cnt++; r_pend = 1;
          if (axi.ARADDR !== exp_addr) addr_bad++;
        end
        if (gap_on && axi.ARVALID) begin
          if (gap_run != PG) gap_bad++;
          gap_on = 0;
        end else if (gap_on && !(axi.AWVALID || axi.WVALID || axi.ARVALID)) gap_run++;
        if (r_hs) begin gap_on = 1; gap_run = 0; end
        if (rsp_valid) gap_on = 0;
      end
      @(negedge ACLK);
      if (ARESET) begin
        axi.AWREADY = 0; axi.WREADY = 0; axi.ARREADY = 0; axi.BVALID = 0; axi.RVALID = 0;
      end else begin
        axi.AWREADY = 1'($urandom_range(0, 1));
        axi.WREADY  = ($urandom_range(0, 2) == 0);
        axi.ARREADY = ($urandom_range(0, 2) == 0);
        if (b_hs) begin
          axi.BVALID = 0; aw_got = 0; w_got = 0;
        end else if (aw_got && w_got && !axi.BVALID && !b_hold && $urandom_range(0, 1) == 1) begin
          axi.BVALID = 1; axi.BRESP = plan_b;
        end
        if (r_hs) begin
          axi.RVALID = 0; rd_idx++; r_pend = 0;
        end else if (r_pend && !axi.RVALID && !r_hold && $urandom_range(0, 1) == 1) begin
          axi.RVALID = 1; axi.RDATA = plan_d[rd_idx % PM]; axi.RRESP = plan_r[rd_idx % PM];
        end
      end
    end
  end

  task automatic clear_obs(input logic [AW-1:0] a);
    exp_addr = a; rd_idx = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    addr_bad = 0; ar_unstable = 0; gap_bad = 0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [3:0] ws, input logic [DW-1:0] m);
    int n = 0;
    @(negedge ACLK);
    cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws; cmd_mask = m; cmd_valid = 1;
    while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) check("cmd_accept_timeout", 0, 1);
    @(negedge ACLK);
    cmd_valid = 0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [3:0] ws, input logic [DW-1:0] m, input int hold);
    logic [DW-1:0] e_data, d;
    logic [1:0]    e_resp, r;
    logic          e_to, t;
    int            e_reads, n, hold_bad;
    e_to = 0; e_reads = 0; e_data = '0; e_resp = 2'b00;
    if (op == 2'b00) begin
      e_resp = plan_b;
    end else if (op != 2'b10) begin
      e_reads = 1; e_data = plan_d[0]; e_resp = plan_r[0];
    end else begin
      for (int i = 0; i < PM; i++) begin
        e_reads = i + 1; e_data = plan_d[i]; e_resp = plan_r[i];
        if (plan_r[i] != 2'b00) break;
        if ((plan_d[i] & m) == (wd & m)) break;
        if (i == PM - 1) e_to = 1;
      end
    end
    clear_obs(a);
    send_cmd(op, a, wd, ws, m);
    n = 0;
    while (!rsp_valid && n < 2000) begin @(negedge ACLK); n++; end
    if (n >= 2000) begin
      check("rsp_wait_timeout", 0, 1);
      return;
    end
    d = rsp_data; r = rsp_resp; t = rsp_timeout;
    hold_bad = 0;
    cmd_valid = 1; cmd_op = 2'($urandom_range(0, 3));
    for (int k = 0; k < hold; k++) begin
      @(negedge ACLK);
      if (!rsp_valid || rsp_data !== d || rsp_resp !== r || rsp_timeout !== t || cmd_ready !== 1'b0 ||
          (axi.AWVALID || axi.WVALID || axi.ARVALID)) hold_bad++;
    end
    cmd_valid = 0;
    check("rsp_hold_stable", 64'(hold_bad), 0);
    rsp_ready = 1;
    @(negedge ACLK);
    rsp_ready = 0;
    check("rsp_data", 64'(d), 64'(e_data));
    check("rsp_resp", 64'(r), 64'(e_resp));
    check("rsp_timeout", 64'(t), 64'(e_to));
    check("ar_count", 64'(ar_cnt), 64'(e_reads));
    check("aw_w_count", {32'(aw_cnt), 32'(w_cnt)}, (op == 2'b00) ? {32'd1, 32'd1} : 64'd0);
    if (op == 2'b00) check("write_beat", {got_awaddr, got_wstrb, got_wdata}, {a, ws, wd});
    check("ar_addr_and_stable", {32'(addr_bad), 32'(ar_unstable)}, 0);
    check("poll_gap", 64'(gap_bad), 0);
    check("post_rsp_idle", {rsp_valid, cmd_ready, dut_vr()}, {1'b0, 1'b1, 5'b0});
  endtask

  task automatic reset_mid(input bit wr);
    int n = 0;
    b_hold = wr; r_hold = !wr;
    plan_b = 2'b00; plan_d[0] = 32'hdead_beef; plan_r[0] = 2'b00;
    clear_obs(12'h0a4);
    send_cmd(wr ? 2'b00 : 2'b01, 12'h0a4, 32'h5, 4'hf, '0);
    while (!(wr ? axi.BREADY : axi.RREADY) && n < 200) begin @(negedge ACLK); n++; end
    check(wr ? "reach_wr_b" : "reach_rd_r", 64'(n < 200), 1);
    ARESET = 1;
    @(negedge ACLK);
    check(wr ? "reset_in_wr_b" : "reset_in_rd_r", {rsp_valid, cmd_ready, dut_vr()}, 0);
    ARESET = 0; b_hold = 0; r_hold = 0;
    #1;
    check("cmd_ready_after_reset", 64'(cmd_ready), 1);
  endtask

  task automatic rand_plan(input logic [DW-1:0] match, input logic [DW-1:0] m);
    int hit = $urandom_range(0, PM);
    logic [DW-1:0] low = m & (~m + 1'b1);
    plan_b = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    for (int i = 0; i < PM; i++) begin
      plan_d[i] = $urandom;
      if (i == hit) plan_d[i] = (plan_d[i] & ~m) | (match & m);
      else if (((plan_d[i] ^ match) & m) == '0) plan_d[i] = plan_d[i] ^ low;
      plan_r[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    end
  endtask

  initial begin
    logic [DW-1:0] wd, m;
    clear_obs('0);
    repeat (3) @(negedge ACLK);
    check("reset_outputs", {rsp_valid, cmd_ready, dut_vr(), rsp_resp, rsp_timeout}, 0);
    check("reset_rsp_data", 64'(rsp_data), 0);
    ARESET = 0;
    #1;
    check("cmd_ready_out_of_reset", 64'(cmd_ready), 1);

    plan_b = 2'b00;
    run_cmd(2'b00, 12'h010, 32'h1, 4'hf, '0, 0);
    plan_d[0] = 32'h100; plan_r[0] = 2'b00;
    run_cmd(2'b01, 12'h038, '0, '0, '0, 0);
    plan_d[0] = 32'h0; plan_d[1] = 32'h1; plan_d[2] = 32'h3; plan_d[3] = 32'h0;
    for (int i = 0; i < PM; i++) plan_r[i] = 2'b00;
    run_cmd(2'b10, 12'h000, 32'h2, '0, 32'h2, 0);
    for (int i = 0; i < PM; i++) plan_d[i] = 32'h10 + 32'(i);
    run_cmd(2'b10, 12'h000, 32'h2, '0, 32'h2, 5);
    plan_d[0] = 32'h77; plan_r[0] = 2'b10;
    run_cmd(2'b10, 12'h004, 32'h1, '0, 32'h1, 0);
    run_cmd(2'b01, 12'h008, '0, '0, '0, 5);

    reset_mid(1'b1);
    reset_mid(1'b0);

    for (int c = 0; c < 40; c++) begin
      wd = $urandom;
      m = $urandom | 32'h1 << $urandom_range(0, 31);
      rand_plan(wd, m);
      run_cmd(2'($urandom_range(0, 3)), 12'($urandom), wd, 4'($urandom), m, $urandom_range(0, 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
